// File: rtl/message_feed_buffer_if.sv
// message_feed_buffer_if
//   Bundles the feed-buffer handshakes into one interface.
//   Upstream side (partial message counter):
//     in_msg[63:0], in_valid, in_done  -> buffer
//     pause                            <- buffer
//   Downstream side (DES core):
//     out_msg[63:0], out_valid         <- buffer
//     out_ready                        -> buffer
//   Modports:
//     slave  : the buffer itself
//     master : the environment (counter + DES core, or a bench)
interface message_feed_buffer_if;
  logic [63:0] in_msg;
  logic        in_valid;
  logic        in_done;
  logic        pause;
  logic [63:0] out_msg;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_msg, in_valid, in_done, out_ready,
    output pause, out_msg, out_valid
  );

  modport master (
    output in_msg, in_valid, in_done, out_ready,
    input  pause, out_msg, out_valid
  );
endinterface

// File: rtl/message_feed_buffer.sv
// message_feed_buffer
//   First-word-fall-through FIFO between the partial message counter and the
//   DES core. Absorbs the counter's {msg, valid} stream, throttles it with a
//   registered pause, presents the head entry on a valid/ready port, and
//   flags when a region has fully drained after the counter's done.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     flush        synchronous clear (same effect as reset, wins over push/pop)
//     fb           message_feed_buffer_if.slave (in_msg/in_valid/in_done/pause,
//                  out_msg/out_valid/out_ready)
//     occupancy    current entry count, $clog2(DEPTH)+1 bits
//     overflow     sticky: a valid input arrived while full without a pop
//     drained      in_done seen and FIFO emptied (FSM in DONE)
//     msg_count    popped-message count
//
//   Build option:
//     MSG_FEED_COUNT_EN  when defined, msg_count is a wrapping 32-bit pop
//                        counter; otherwise msg_count is tied to zero.
//
//   Parameters:
//     DEPTH        FIFO entries, power of two, >= 4
//     AFULL_SLACK  free entries left when pause asserts, >= 3 (registered
//                  pause plus one cycle of counter pause-to-idle latency)
module message_feed_buffer #(
  parameter int DEPTH       = 8,
  parameter int AFULL_SLACK = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  message_feed_buffer_if.slave     fb,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic                     drained,
  output logic [31:0]              msg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - AFULL_SLACK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Storage is deliberately not reset; out_msg is gated by out_valid so
  // stale or uninitialised entries never reach the core.
  logic [63:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          pause_q, pause_d;
  logic          ovf_q, ovf_d;
  logic          drained_q, drained_d;
  state_e        state_q, state_d;

  logic          out_valid;
  logic          push, pop, drop;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && fb.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = fb.in_valid && ((occ_q < DEPTH_C) || pop);
  assign drop      = fb.in_valid && !push;

  // ---------------------------------------------------------------------
  // Pointer / occupancy / flag next state
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | drop;

    // Power-of-two depth: natural pointer wrap is modulo DEPTH.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // Registered almost-full: decided on the post-edge occupancy so the
    // counter sees pause as early as possible.
    pause_d = (occ_d >= THRESH_C);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      pause_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Region FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // done with nothing buffered is the empty-region case; done together
        // with a first push still has data to drain.
        if (fb.in_done)  state_d = (occ_d == '0) ? DONE : DRAIN;
        else if (push)   state_d = STREAM;
      end
      STREAM: if (fb.in_done)     state_d = DRAIN;
      DRAIN:  if (occ_d == '0)    state_d = DONE;
      DONE:                       state_d = DONE;
      default:                    state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;

    drained_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      pause_q   <= 1'b0;
      ovf_q     <= 1'b0;
      drained_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      pause_q   <= pause_d;
      ovf_q     <= ovf_d;
      drained_q <= drained_d;
      state_q   <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= fb.in_msg;
  end

  // ---------------------------------------------------------------------
  // Optional pop counter
  // ---------------------------------------------------------------------
`ifdef MSG_FEED_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (flush) cnt_q <= '0;
    else if (pop)   cnt_q <= cnt_q + 32'd1;
  end

  assign msg_count = cnt_q;
`else
  assign msg_count = '0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign fb.out_valid = out_valid;
  assign fb.out_msg   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fb.pause     = pause_q;
  assign occupancy    = occ_q;
  assign overflow     = ovf_q;
  assign drained      = drained_q;

endmodule

// File: tb/tb_message_feed_buffer.sv
// tb_message_feed_buffer
//   Self-checking bench for message_feed_buffer (DEPTH=8, AFULL_SLACK=3).
//   Table of burst-fill / drop / full push+pop vectors, a scoreboarded
//   random stream of 1000 messages, and hand sequences for drain, flush and
//   asynchronous reset.
module tb_message_feed_buffer;

  localparam int DEPTH = 8;
  localparam int SLACK = 3;
  localparam int NMSG  = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  occupancy;
  logic        overflow;
  logic        drained;
  logic [31:0] msg_count;

  int ncmp = 0;
  int nerr = 0;

  message_feed_buffer_if bus ();

  message_feed_buffer #(.DEPTH(DEPTH), .AFULL_SLACK(SLACK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fb        (bus),
    .occupancy (occupancy),
    .overflow  (overflow),
    .drained   (drained),
    .msg_count (msg_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [63:0] msg;
    logic        rdy;
    int          occ;
    logic        pause;
    logic        ovf;
    logic        ov;
    logic [63:0] head;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [63:0] m, input logic rd,
                     input logic dn, input logic fl);
    bus.in_valid  = iv;
    bus.in_msg    = m;
    bus.out_ready = rd;
    bus.in_done   = dn;
    flush         = fl;
  endtask

  function automatic vec_t mk(input logic iv, input logic [63:0] m, input logic rdy,
                              input int occ, input logic p, input logic ovf,
                              input logic [63:0] head);
    vec_t v;
    v.iv = iv; v.msg = m; v.rdy = rdy; v.occ = occ; v.pause = p; v.ovf = ovf;
    v.ov = (occ != 0); v.head = head;
    return v;
  endfunction

  vec_t        vt[$];
  logic [63:0] sb[$];

  initial begin
    int exp_cnt;

    // ------------------------------------------------------------ reset
    rst_n = 1'b0;
    drv(0, '0, 0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_msg",   bus.out_msg,   0);
    chk("rst_pause",     bus.pause,     0);
    chk("rst_occ",       occupancy,     0);
    chk("rst_overflow",  overflow,      0);
    chk("rst_drained",   drained,       0);
    chk("rst_msg_count", msg_count,     0);
    rst_n = 1'b1;
    tick();

    // ------------------------------------------------------------ table
    // Burst fill 0..7 with out_ready low; pause follows the 5th push.
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(1, 64'(i), 0, i + 1, (i + 1) >= 5, 0, 64'h0));
    // Push while full and not popping: dropped, overflow sticky.
    vt.push_back(mk(1, 64'hDEAD, 0, 8, 1, 1, 64'h0));
    vt.push_back(mk(0, 64'h0,    0, 8, 1, 1, 64'h0));
    // Full with simultaneous push/pop: occupancy holds, head advances.
    vt.push_back(mk(1, 64'h55,   1, 8, 1, 1, 64'h1));
    // Drain: 1..7 then 0x55 surfaces after the 8th pop since it was pushed.
    for (int r = 1; r <= 7; r++)
      vt.push_back(mk(0, 64'h0, 1, 8 - r, (8 - r) >= 5, 1, (r < 7) ? 64'(r + 1) : 64'h55));
    vt.push_back(mk(0, 64'h0, 1, 0, 0, 1, 64'h0));

    for (int i = 0; i < vt.size(); i++) begin
      drv(vt[i].iv, vt[i].msg, vt[i].rdy, 0, 0);
      tick();
      chk($sformatf("vec%0d_occ", i),       occupancy,     64'(vt[i].occ));
      chk($sformatf("vec%0d_pause", i),     bus.pause,     vt[i].pause);
      chk($sformatf("vec%0d_overflow", i),  overflow,      vt[i].ovf);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vt[i].ov);
      chk($sformatf("vec%0d_out_msg", i),   bus.out_msg,   vt[i].head);
    end

`ifdef MSG_FEED_COUNT_EN
    exp_cnt = 9;
`else
    exp_cnt = 0;
`endif
    chk("table_msg_count", msg_count, 32'(exp_cnt));

    // ------------------------------------------------- flush beats push
    drv(1, 64'h77, 1, 0, 1);
    tick();
    chk("flush_occ",      occupancy,     0);
    chk("flush_overflow", overflow,      0);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_msg_count", msg_count,    0);

    // ------------------------------------------------- FWFT latency
    drv(1, 64'h1_0000_0000, 0, 0, 0);
    @(negedge clk);
    chk("lat_pre_valid", bus.out_valid, 0);
    tick();
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_msg",   bus.out_msg,   64'h1_0000_0000);
    drv(0, '0, 0, 0, 1);
    tick();
    drv(0, '0, 0, 0, 0);

    // ------------------------------------------------- scoreboarded stream
    begin
      int   sent = 0;
      int   got  = 0;
      int   cyc  = 0;
      bit   pd   = 0;
      bit   pop, push;
      int   occ_m;
      logic [63:0] m;
      sb.delete();
      while (got < NMSG && cyc < 20000) begin
        m = 64'(sent) ^ 64'hA5A5_0000_0000_0000;
        bus.in_valid  = (sent < NMSG) && !pd && ($urandom_range(0, 3) != 0);
        bus.in_msg    = m;
        bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        occ_m = sb.size();
        if (occupancy != 4'(occ_m)) chk("stream_occ", occupancy, 64'(occ_m));
        pop  = bus.out_valid && bus.out_ready;
        push = bus.in_valid && (occ_m < DEPTH || pop);
        if (pop) begin
          if (sb.size() == 0) chk("stream_pop_unexpected", bus.out_valid, 0);
          else chk("stream_data", bus.out_msg, sb.pop_front());
          got++;
        end
        if (push) sb.push_back(m);
        if (bus.in_valid) sent++;
        pd = bus.pause;
        tick();
        cyc++;
      end
      chk("stream_got",      64'(got), 64'(NMSG));
      chk("stream_overflow", overflow, 0);
      chk("stream_empty",    bus.out_valid, 0);
    end
`ifdef MSG_FEED_COUNT_EN
    exp_cnt = NMSG;
`else
    exp_cnt = 0;
`endif
    chk("stream_msg_count", msg_count, 32'(exp_cnt));

    // ------------------------------------------------- drain sequence
    drv(0, '0, 0, 0, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1, 64'(k + 100), 0, 0, 0);
      tick();
    end
    chk("drain_occ3", occupancy, 3);
    drv(0, '0, 1, 1, 0);
    tick();
    chk("drain_e0", drained, 0);
    drv(0, '0, 1, 0, 0);
    tick();
    chk("drain_e1", drained, 0);
    tick();
    chk("drain_e2", drained, 1);
    chk("drain_occ0", occupancy, 0);
    tick();
    chk("drain_hold", drained, 1);
    drv(0, '0, 0, 0, 1);
    tick();
    chk("drain_flush_drained", drained, 0);
    chk("drain_flush_occ", occupancy, 0);
    drv(0, '0, 0, 1, 0);
    tick();
    chk("empty_region_drained", drained, 1);
    drv(0, '0, 0, 0, 1);
    tick();
    chk("empty_region_flush", drained, 0);

    // ------------------------------------------------- async reset mid-run
    for (int k = 0; k < 5; k++) begin
      drv(1, 64'(k + 200), 0, 0, 0);
      tick();
    end
    chk("mid_occ5",  occupancy, 5);
    chk("mid_pause", bus.pause, 1);
    drv(0, '0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_pause",     bus.pause,     0);
    chk("arst_overflow",  overflow,      0);
    chk("arst_occ",       occupancy,     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // ------------------------------------------------- flush mid-run
    for (int k = 0; k < 5; k++) begin
      drv(1, 64'(k + 300), 0, 0, 0);
      tick();
    end
    chk("mid2_pause", bus.pause, 1);
    drv(0, '0, 0, 0, 1);
    tick();
    chk("mflush_out_valid", bus.out_valid, 0);
    chk("mflush_pause",     bus.pause,     0);
    chk("mflush_overflow",  overflow,      0);
    chk("mflush_occ",       occupancy,     0);
    drv(0, '0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/message_feed_buffer.md
Name: message_feed_buffer

Overview:
- Downstream neighbour of the partial message counter; sits between the counter and the DES core.
- Absorbs the counter's `{counter, valid}` stream into a first-word-fall-through FIFO and presents messages to the DES core over a valid/ready handshake.
- Drives the counter's `pause` input so that no message is lost, and reports when a region is fully drained after the counter's `done`.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- AFULL_SLACK, 3, free entries still left when `pause` asserts. Must be ≥ 3 to cover the registered `pause` plus the counter's one-cycle pause-to-idle latency.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active low
- flush  input  1  synchronous clear, driven together with the counter's `reset_counter`
- in_msg  input  64  message from the counter (`counter` output)
- in_valid  input  1  `in_msg` valid this cycle (counter `valid`)
- in_done  input  1  counter `done`: region exhausted
- pause  output  1  to counter `pause`; registered
- out_msg  output  64  FIFO head to DES core
- out_valid  output  1  `out_msg` valid
- out_ready  input  1  DES core accepts `out_msg` this cycle
- occupancy  output  $clog2(DEPTH)+1  current entry count
- overflow  output  1  sticky: a valid input was dropped
- drained  output  1  `in_done` seen and FIFO empty
- msg_count  output  32  popped-message count (see Optional Feature)

Behaviour:
- Async reset values:
  - pointers and occupancy = 0; state = IDLE
  - `pause` = 0, `out_valid` = 0, `overflow` = 0, `drained` = 0, `msg_count` = 0
  - `out_msg` = 0 (storage need not reset)
- `flush`:
  - Same cycle, same effect as reset, synchronously.
  - Takes priority over simultaneous push and pop.
  - Contents are discarded.
- Push = `in_valid` && (occupancy < DEPTH || pop). Pop = `out_valid` && `out_ready`.
- Simultaneous push and pop: occupancy unchanged, including when the FIFO is full.
- Dropped input: `in_valid` while full with no pop → data dropped, `overflow` set the next cycle and held until `flush` or reset.
- `out_valid` = (occupancy != 0); `out_msg` = head entry. Output is combinational from registers only.
- Latency: a message pushed at edge N is visible on `out_msg` after edge N (FWFT, one cycle).
- `pause` <= (occupancy_next ≥ DEPTH − AFULL_SLACK), registered. It deasserts one cycle after occupancy_next drops below the threshold.
- `in_msg` is stored verbatim; no bit reordering.
- Pointers wrap modulo DEPTH; occupancy is a full-width counter and never wraps.
- FSM (registered state):
  - IDLE: empty, waiting. Go to STREAM on the first push.
  - STREAM: go to DRAIN when `in_done` = 1. `in_valid` in the same cycle as `in_done` is still pushed.
  - DRAIN: pushes still accepted. Go to DONE when occupancy_next == 0.
  - DONE: `drained` = 1 (registered with state). Stay until `flush`, then go to IDLE.
  - `in_done` while in IDLE goes directly to DONE; this is the empty-region case.
- `drained` is 0 in every state except DONE.

Optional Feature:
- Macro `MSG_FEED_COUNT_EN`.
- Defined:
  - `msg_count` is a 32-bit counter incremented on every pop.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset and `flush`.
- Undefined: `msg_count` is tied to 0 and no counter logic is instantiated.

Test Plan:
- Burst fill, DEPTH = 8, AFULL_SLACK = 3, `out_ready` = 0, messages 0x0..0x7 on consecutive cycles:
  - `pause` rises the cycle after the 5th push (occupancy_next = 5).
  - Occupancy saturates at 8 and `overflow` stays 0 when the counter model stops one cycle after `pause`.
- Drop: hold `out_ready` = 0 with occupancy 8, drive `in_valid` with 0xDEAD → occupancy stays 8, `overflow` = 1 next cycle, 0xDEAD never appears on `out_msg`.
- Full simultaneous push and pop: occupancy 8, `out_ready` = 1, push 0x55 → occupancy stays 8, `out_msg` advances to the 2nd entry, 0x55 emerges 8 pops later.
- Ordering and latency:
  - Push 0x1_00000000 at edge N → `out_valid` = 1 with that value after edge N.
  - Random `out_ready` over 1000 counter messages → output sequence identical to input, no gaps or duplicates.
  - `msg_count` = 1000 with `MSG_FEED_COUNT_EN` defined, 0 without.
- Drain: `in_done` with occupancy 3, `out_ready` = 1 → `drained` rises 3 cycles later.
  - `flush` then returns to IDLE with `drained` = 0 and occupancy 0.
  - `in_done` with an empty FIFO in IDLE → `drained` = 1 the next cycle.
- Mid-operation reset and flush: with occupancy 5 and `pause` = 1, assert `rst_n` = 0 asynchronously between edges → `out_valid`, `pause`, `overflow` and occupancy drop to 0 immediately. Repeat with `flush` → same values after the next edge.
